// File: rtl/sfifo_ext_if.sv
// Producer/consumer handshake bundle for sfifo_ext: push/pop strobes, data and status.
interface sfifo_ext_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
);
  logic             store;
  logic             read;
  logic [WIDTH-1:0] wdata;
  logic             clear_err;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             full;
  logic [DEPTH:0]   count;
  logic             afull;
  logic             aempty;
  logic             overflow;
  logic             underflow;

  modport master (
    output store, read, wdata, clear_err,
    input  rdata, empty, full, count, afull, aempty, overflow, underflow
  );

  modport slave (
    input  store, read, wdata, clear_err,
    output rdata, empty, full, count, afull, aempty, overflow, underflow
  );
endinterface

// File: rtl/sfifo_ext.sv
// Synchronous FIFO using all 2^DEPTH slots, with occupancy, programmable
// almost flags, sticky error flags and optional first-word-fall-through read.
module sfifo_ext #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 2,
  parameter bit          FWFT   = 1'b0,
  parameter int unsigned AFULL  = (2**DEPTH) - 1,
  parameter int unsigned AEMPTY = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  sfifo_ext_if.slave bus
);
  localparam logic [DEPTH:0] N_ENT = (DEPTH+1)'(1) << DEPTH;

  logic [WIDTH-1:0] mem_q [2**DEPTH];
  logic [DEPTH:0]   wpos_q, wpos_d, rpos_q, rpos_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [DEPTH:0]   count;
  logic             empty, full, rd_ok, wr_ok;

  // Status comes only from registered pointers; the extra wrap bit
  // distinguishes full from empty so every slot is usable.
  assign count = wpos_q - rpos_q;
  assign empty = (count == '0);
  assign full  = (count == N_ENT);

  assign rd_ok = bus.read & ~empty;
  assign wr_ok = bus.store & (~full | rd_ok);

  always_comb begin
    wpos_d = wpos_q;
    rpos_d = rpos_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (wr_ok) wpos_d = wpos_q + 1'b1;
    if (rd_ok) rpos_d = rpos_q + 1'b1;
    if (bus.clear_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (bus.store & ~wr_ok) ovf_d = 1'b1;
    if (bus.read  & ~rd_ok) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wpos_q <= '0;
      rpos_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wpos_q <= wpos_d;
      rpos_q <= rpos_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage is deliberately not reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (wr_ok && reset_n) mem_q[wpos_q[DEPTH-1:0]] <= bus.wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.rdata = mem_q[rpos_q[DEPTH-1:0]];
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   rdata_q <= '0;
        else if (rd_ok) rdata_q <= mem_q[rpos_q[DEPTH-1:0]];
      end
      assign bus.rdata = rdata_q;
    end
  endgenerate

  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count;
  assign bus.afull     = (32'(count) >= AFULL);
  assign bus.aempty    = (32'(count) <= AEMPTY);
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
